// File: rtl/soc_system_sprite_mem_arbiter.sv
// soc_system_sprite_mem_arbiter: shares one single-port sprite RAM between the display fetcher and the Avalon host
module soc_system_sprite_mem_arbiter #(
    parameter int ADDR_W = 11,
    parameter int DATA_W = 8,
    parameter int LEN_W  = 7
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_base,
    input  logic [LEN_W-1:0]  disp_len,
    output logic              disp_ack,
    output logic [DATA_W-1:0] disp_data,
    output logic              disp_valid,
    output logic              disp_done,
    input  logic [ADDR_W-1:0] host_address,
    input  logic              host_read,
    input  logic              host_write,
    input  logic [DATA_W-1:0] host_writedata,
    output logic              host_waitrequest,
    output logic [DATA_W-1:0] host_readdata,
    output logic              host_readdatavalid,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_wren,
    output logic [DATA_W-1:0] mem_writedata,
    input  logic [DATA_W-1:0] mem_readdata
);
    typedef enum logic [1:0] {IDLE, DISP, DRAIN, HOST} state_t;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << (LEN_W - 1);
    state_t            state;
    logic              host_turn;
    logic              host_rd_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt;
    logic [LEN_W-1:0]  cnt_nx;
    logic              host_pend;
    logic              last;
    assign host_pend = host_read | host_write;
    assign cnt_nx    = cnt + LEN_W'(1);
    assign last      = cnt == len_q - LEN_W'(1);
    // RAM data is steered to whichever requester the delayed owner tag (the valid flags) names
    assign disp_data     = disp_valid ? mem_readdata : '0;
    assign host_readdata = host_readdatavalid ? mem_readdata : '0;
    // arbitration FSM: display priority, host guaranteed one slot after a burst it waited through
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            host_turn          <= 1'b0;
            host_rd_q          <= 1'b0;
            base_q             <= '0;
            len_q              <= '0;
            cnt                <= '0;
            disp_ack           <= 1'b0;
            disp_valid         <= 1'b0;
            disp_done          <= 1'b0;
            host_waitrequest   <= 1'b1;
            host_readdatavalid <= 1'b0;
            mem_address        <= '0;
            mem_wren           <= 1'b0;
            mem_writedata      <= '0;
        end else begin
            disp_ack           <= 1'b0;
            disp_valid         <= state == DISP;
            disp_done          <= state == DISP && last;
            host_readdatavalid <= state == HOST && host_rd_q;
            host_waitrequest   <= 1'b1;
            mem_wren           <= 1'b0;
            case (state)
                IDLE: begin
                    if (host_pend && (host_turn || !disp_req)) begin
                        state            <= HOST;
                        mem_address      <= host_address;
                        mem_wren         <= host_write;
                        mem_writedata    <= host_writedata;
                        host_rd_q        <= host_read && !host_write;
                        host_waitrequest <= 1'b0;
                    end else if (disp_req) begin
                        state       <= DISP;
                        disp_ack    <= 1'b1;
                        base_q      <= disp_base;
                        len_q       <= disp_len == '0 ? MAX_LEN : disp_len;
                        cnt         <= '0;
                        mem_address <= disp_base;
                    end
                end
                DISP: begin
                    if (last) begin
                        state <= DRAIN;
                        if (host_pend) host_turn <= 1'b1;
                    end else begin
                        cnt         <= cnt_nx;
                        mem_address <= base_q + ADDR_W'(cnt_nx);
                    end
                end
                DRAIN: state <= IDLE;
                HOST: begin
                    state     <= IDLE;
                    host_turn <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_soc_system_sprite_mem_arbiter.sv
// tb_soc_system_sprite_mem_arbiter: table-driven bursts plus host/contention/reset sequences with scoreboards
module tb_soc_system_sprite_mem_arbiter;
    logic        clk;
    logic        reset_n;
    logic        disp_req;
    logic [10:0] disp_base;
    logic [6:0]  disp_len;
    logic        disp_ack;
    logic [7:0]  disp_data;
    logic        disp_valid;
    logic        disp_done;
    logic [10:0] host_address;
    logic        host_read;
    logic        host_write;
    logic [7:0]  host_writedata;
    logic        host_waitrequest;
    logic [7:0]  host_readdata;
    logic        host_readdatavalid;
    logic [10:0] mem_address;
    logic        mem_wren;
    logic [7:0]  mem_writedata;
    logic [7:0]  mem_readdata;

    soc_system_sprite_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .disp_req(disp_req), .disp_base(disp_base), .disp_len(disp_len),
        .disp_ack(disp_ack), .disp_data(disp_data), .disp_valid(disp_valid), .disp_done(disp_done),
        .host_address(host_address), .host_read(host_read), .host_write(host_write),
        .host_writedata(host_writedata), .host_waitrequest(host_waitrequest),
        .host_readdata(host_readdata), .host_readdatavalid(host_readdatavalid),
        .mem_address(mem_address), .mem_wren(mem_wren), .mem_writedata(mem_writedata),
        .mem_readdata(mem_readdata)
    );

    typedef struct {
        logic [7:0] data;
        logic       done;
    } exp_t;
    typedef struct {
        logic [10:0] base;
        logic [6:0]  len;
        int          exp_n;
        logic [7:0]  exp_last;
    } vec_t;

    logic [7:0] ram [2048];
    logic [7:0] ref_ram [2048];
    exp_t       dq[$];
    logic [7:0] hq[$];
    int         passed = 0;
    int         total = 0;
    int         vcount = 0;
    logic [7:0] last_data = '0;
    logic       contend = 1'b0;
    int         bursts_since_host = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM macro model: registered address, one-cycle read latency
    always @(posedge clk) begin
        if (mem_wren) ram[mem_address] <= mem_writedata;
        mem_readdata <= ram[mem_address];
    end

    function automatic void check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endfunction

    // output monitor: pops the scoreboards whenever the DUT produces data
    always @(negedge clk) begin
        if (reset_n) begin
            if (disp_valid) begin
                vcount++;
                last_data = disp_data;
                if (dq.size() == 0) check("disp_extra_valid", 1, 0);
                else begin
                    exp_t e;
                    e = dq.pop_front();
                    check("disp_data", int'(disp_data), int'(e.data));
                    check("disp_done", int'(disp_done), int'(e.done));
                end
            end else if (disp_done) check("done_without_valid", 1, 0);
            if (host_readdatavalid) begin
                if (hq.size() == 0) check("host_extra_rdv", 1, 0);
                else check("host_readdata", int'(host_readdata), int'(hq.pop_front()));
            end
            if (disp_valid && host_readdatavalid) check("valid_overlap", 1, 0);
            if (!host_waitrequest) begin
                if (contend) check("alternation", int'(bursts_since_host <= 1), 1);
                bursts_since_host = 0;
            end
            if (disp_ack) bursts_since_host++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic burst(input logic [10:0] base, input logic [6:0] len, output int ack_lat, output int done_lat);
        int n;
        n = len == 0 ? 64 : int'(len);
        for (int i = 0; i < n; i++) dq.push_back('{ref_ram[(int'(base) + i) % 2048], i == n - 1});
        vcount = 0;
        disp_req = 1'b1;
        disp_base = base;
        disp_len = len;
        ack_lat = 0;
        done_lat = 0;
        do begin tick(); ack_lat++; end while (!disp_ack && ack_lat < 300);
        disp_req = 1'b0;
        if (!disp_ack) begin
            check("ack_timeout", 0, 1);
            dq.delete();
            return;
        end
        do begin tick(); done_lat++; end while (!disp_done && done_lat < 300);
        if (!disp_done) begin
            check("done_timeout", 0, 1);
            dq.delete();
        end
    endtask

    task automatic host_acc(input logic [10:0] a, input logic rd, input logic wr, input logic [7:0] wd, output int wait_c);
        host_address = a;
        host_read = rd;
        host_write = wr;
        host_writedata = wd;
        if (rd && !wr) hq.push_back(ref_ram[a]);
        wait_c = 0;
        do begin tick(); wait_c++; end while (host_waitrequest && wait_c < 300);
        if (host_waitrequest) begin
            check("host_timeout", 0, 1);
            hq.delete();
            host_read = 1'b0;
            host_write = 1'b0;
            return;
        end
        if (wr) ref_ram[a] = wd;
        @(posedge clk);
        #1;
        host_read = 1'b0;
        host_write = 1'b0;
        tick();
        check("waitreq_one_cycle", int'(host_waitrequest), 1);
        check("rdv_timing", int'(host_readdatavalid), int'(rd && !wr));
    endtask

    initial begin
        automatic vec_t vt[5];
        int al, dl, w;
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vt[5];
        int al, dl, w;
        for (int i = 0; i < 2048; i++) begin
            ram[i] = 8'(i);
            ref_ram[i] = 8'(i);
        end
        vt[0] = '{11'h010, 7'd4, 4, 8'h13};
        vt[1] = '{11'h7FE, 7'd4, 4, 8'h01};
        vt[2] = '{11'h000, 7'd0, 64, 8'h3F};
        vt[3] = '{11'h3F0, 7'd1, 1, 8'hF0};
        vt[4] = '{11'h7C0, 7'd64, 64, 8'hFF};
        reset_n = 1'b0;
        disp_req = 1'b0;
        disp_base = '0;
        disp_len = '0;
        host_address = '0;
        host_read = 1'b0;
        host_write = 1'b0;
        host_writedata = '0;
        repeat (3) tick();
        check("rst_waitrequest", int'(host_waitrequest), 1);
        check("rst_disp_valid", int'(disp_valid), 0);
        check("rst_disp_ack", int'(disp_ack), 0);
        check("rst_mem_wren", int'(mem_wren), 0);
        reset_n = 1'b1;
        tick();

        for (int k = 0; k < 5; k++) begin
            burst(vt[k].base, vt[k].len, al, dl);
            tick();
            check("ack_latency", al, 1);
            check("valid_count", vcount, vt[k].exp_n);
            check("done_latency", dl, vt[k].exp_n);
            check("last_byte", int'(last_data), int'(vt[k].exp_last));
            check("disp_sb_empty", dq.size(), 0);
        end

        host_acc(11'h123, 1'b0, 1'b1, 8'hA5, w);
        check("host_write_wait", w, 1);
        host_acc(11'h123, 1'b1, 1'b0, 8'h00, w);
        check("host_read_wait", w, 1);
        tick();
        check("host_sb_empty", hq.size(), 0);

        contend = 1'b1;
        bursts_since_host = 0;
        fork
            begin
                int a2, d2;
                for (int k = 0; k < 3; k++) begin
                    burst(11'h200 + 11'(k * 8), 7'd8, a2, d2);
                    check("contend_done_lat", d2, 8);
                end
            end
            begin
                int w2;
                tick();
                for (int k = 0; k < 3; k++) begin
                    host_acc(11'h201 + 11'(k), 1'b1, 1'b0, 8'h00, w2);
                    check("host_wait_bound", int'(w2 <= 14), 1);
                end
                host_acc(11'h300, 1'b1, 1'b1, 8'h5A, w2);
                check("host_wait_bound_rw", int'(w2 <= 14), 1);
            end
        join
        contend = 1'b0;
        host_acc(11'h300, 1'b1, 1'b0, 8'h00, w);
        repeat (2) tick();
        check("contend_disp_sb", dq.size(), 0);
        check("contend_host_sb", hq.size(), 0);

        for (int i = 0; i < 16; i++) dq.push_back('{ref_ram[256 + i], i == 15});
        disp_req = 1'b1;
        disp_base = 11'h100;
        disp_len = 7'd16;
        al = 0;
        do begin tick(); al++; end while (!disp_ack && al < 300);
        disp_req = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0;
        #1;
        check("midrst_disp_valid", int'(disp_valid), 0);
        check("midrst_disp_done", int'(disp_done), 0);
        check("midrst_disp_data", int'(disp_data), 0);
        check("midrst_waitrequest", int'(host_waitrequest), 1);
        check("midrst_mem_address", int'(mem_address), 0);
        check("midrst_rdv", int'(host_readdatavalid), 0);
        dq.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        vcount = 0;
        repeat (20) tick();
        check("no_stray_valid", vcount, 0);
        burst(11'h010, 7'd4, al, dl);
        tick();
        check("post_rst_ack", al, 1);
        check("post_rst_done", dl, 4);
        check("post_rst_last", int'(last_data), 8'h13);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
